data_mem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS pipeline's MEM stage. It accepts load and store requests, stalls the pipeline while the access is in flight, and returns read data with a one-cycle `Done` pulse. It replaces the single-cycle data memory so the pipeline can run against realistic memory latency.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/dm_array.sv | 27 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } memState_e;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    // Wide enough to hold LATENCY_MAX - 1.
    localparam int unsigned COUNT_W     = 4;

    // Pick one little-endian byte lane out of a word (lane 0 is bits [7:0]).
    function automatic logic [7:0] laneSelect(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
interface data_mem_responder_if;

    logic        MemRead;
    logic        MemWrite;
    logic        Byte;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        Error;

    modport master (
        output MemRead, MemWrite, Byte, Address, WriteData,
        input  ReadData, Stall, Done, Error
    );

    modport slave (
        input  MemRead, MemWrite, Byte, Address, WriteData,
        output ReadData, Stall, Done, Error
    );

endinterface

// File: rtl/dm_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read.
module dm_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AddrW       = 10
) (
    input  logic                  Clk,
    input  logic [AddrW-1:0]      addr,
    input  logic [WORD_BYTES-1:0] byteEn,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes and read-before-write registered read of the same word.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (byteEn[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline while an access
// is in flight and reports completion with a one-cycle Done pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 Clk,
    input logic                 Rst,
    data_mem_responder_if.slave bus
);

    // Out-of-range LATENCY is clamped to the supported window.
    localparam int unsigned LatencyEff = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int unsigned AddrW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [COUNT_W-1:0] CountInit = COUNT_W'(LatencyEff - 1);
    localparam bit SingleCycle = (LatencyEff == 1);

    memState_e             stateQ;
    logic [COUNT_W-1:0]    countQ;
    logic                  readQ, writeQ, byteQ;
    logic [31:0]           addrQ, wdataQ;
    logic                  doneQ, errorQ, loadQ;

    logic                  reqIn, enterResp;
    logic                  curRead, curWrite, curByte, curIllegal;
    logic [31:0]           curAddr, curWdata;
    logic [AddrW-1:0]      ramAddr;
    logic [WORD_BYTES-1:0] ramByteEn;
    logic [31:0]           ramWdata, ramRdata;

    // The request being served: live inputs while idle (needed when LATENCY=1), else the capture.
    always_comb begin
        reqIn = bus.MemRead | bus.MemWrite;
        if (stateQ == StIdle) begin
            curRead  = bus.MemRead;
            curWrite = bus.MemWrite;
            curByte  = bus.Byte;
            curAddr  = bus.Address;
            curWdata = bus.WriteData;
        end else begin
            curRead  = readQ;
            curWrite = writeQ;
            curByte  = byteQ;
            curAddr  = addrQ;
            curWdata = wdataQ;
        end

        curIllegal = (curRead & curWrite)
                   | (~curByte & (curAddr[1:0] != 2'b00))
                   | ({2'b00, curAddr[31:2]} >= DEPTH_WORDS);

        enterResp = ((stateQ == StIdle) & reqIn & SingleCycle)
                  | ((stateQ == StWait) & (countQ == COUNT_W'(1)));

        ramAddr   = curAddr[AddrW+1:2];
        ramWdata  = curByte ? {WORD_BYTES{curWdata[7:0]}} : curWdata;
        ramByteEn = '0;
        // Stores commit on the edge into RESP; a reset on that edge cancels them.
        if (Rst && enterResp && curWrite && !curIllegal) begin
            ramByteEn = curByte ? (WORD_BYTES'(1) << curAddr[1:0]) : '1;
        end
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AddrW       (AddrW)
    ) uArray (
        .Clk    (Clk),
        .addr   (ramAddr),
        .byteEn (ramByteEn),
        .wdata  (ramWdata),
        .rdata  (ramRdata)
    );

    // Request FSM, latency counter, request capture and registered Done/Error.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stateQ <= StIdle;
            countQ <= '0;
            readQ  <= 1'b0;
            writeQ <= 1'b0;
            byteQ  <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            doneQ  <= 1'b0;
            errorQ <= 1'b0;
            loadQ  <= 1'b0;
        end else begin
            doneQ  <= 1'b0;
            errorQ <= 1'b0;
            loadQ  <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (reqIn) begin
                        readQ  <= bus.MemRead;
                        writeQ <= bus.MemWrite;
                        byteQ  <= bus.Byte;
                        addrQ  <= bus.Address;
                        wdataQ <= bus.WriteData;
                        countQ <= CountInit;
                        stateQ <= SingleCycle ? StResp : StWait;
                    end
                end
                StWait: begin
                    countQ <= countQ - COUNT_W'(1);
                    if (countQ == COUNT_W'(1)) begin
                        stateQ <= StResp;
                    end
                end
                StResp: begin
                    stateQ <= StIdle;
                end
                default: begin
                    stateQ <= StIdle;
                end
            endcase
            if (enterResp) begin
                doneQ  <= 1'b1;
                errorQ <= curIllegal;
                loadQ  <= curRead & ~curIllegal;
            end
        end
    end

    // Load data comes straight from the RAM output register; zero unless a legal load completes.
    always_comb begin
        bus.ReadData = '0;
        if (doneQ && loadQ) begin
            bus.ReadData = byteQ ? {24'h0, laneSelect(ramRdata, addrQ[1:0])} : ramRdata;
        end
    end

    assign bus.Done  = doneQ;
    assign bus.Error = errorQ;
    assign bus.Stall = Rst & (((stateQ == StIdle) & reqIn) | (stateQ == StWait));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 5, 1) share one request driver; sel picks
// which one receives requests and whose outputs are observed.
module tb_data_mem_responder;

    localparam int unsigned Depth = 64;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        mr = 1'b0, mw = 1'b0, by = 1'b0;
    logic [31:0] ad = '0, wd = '0;

    logic        stallV [3];
    logic        doneV  [3];
    logic        errV   [3];
    logic [31:0] rdV    [3];

    logic        stall, done, error;
    logic [31:0] rdata;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        data_mem_responder_if bus ();
        assign bus.MemRead   = (sel == 2'(g)) & mr;
        assign bus.MemWrite  = (sel == 2'(g)) & mw;
        assign bus.Byte      = (sel == 2'(g)) & by;
        assign bus.Address   = (sel == 2'(g)) ? ad : '0;
        assign bus.WriteData = (sel == 2'(g)) ? wd : '0;
        assign stallV[g] = bus.Stall;
        assign doneV[g]  = bus.Done;
        assign errV[g]   = bus.Error;
        assign rdV[g]    = bus.ReadData;
        data_mem_responder #(
            .DEPTH_WORDS (Depth),
            .LATENCY     ((g == 0) ? 2 : (g == 1) ? 5 : 1)
        ) dut (
            .Clk (clk),
            .Rst (rstN),
            .bus (bus)
        );
    end

    assign stall = stallV[sel];
    assign done  = doneV[sel];
    assign error = errV[sel];
    assign rdata = rdV[sel];

    // Issue one request and hold it until Done (bounded). Returns stall-cycle count and the
    // cycle index of Done counted from the request's first (IDLE) cycle.
    task automatic doReq(input logic r, input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] d, input bit chain, output bit gotDone,
                         output int stallCnt, output int doneAt, output logic err,
                         output logic [31:0] rd);
        @(negedge clk);
        mr = r; mw = w; by = b; ad = a; wd = d;
        gotDone = 1'b0; stallCnt = 0; doneAt = -1; err = 1'b0; rd = '0;
        for (int cyc = 0; cyc < 40 && !gotDone; cyc++) begin
            #1;
            if (stall) stallCnt++;
            if (done) begin
                gotDone = 1'b1;
                doneAt  = cyc;
                err     = error;
                rd      = rdata;
            end else begin
                @(negedge clk);
            end
        end
        if (!chain || !gotDone) begin
            mr = 1'b0; mw = 1'b0; by = 1'b0; ad = '0; wd = '0;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; sel = 2'd0; mr = 1'b1; ad = 32'h40;
        @(negedge clk); @(negedge clk); #1;
        nVec++; if (stall !== 1'b0) begin nMis++; $display("FAIL reset_stall: got %b want 0", stall); end
        nVec++; if (done !== 1'b0) begin nMis++; $display("FAIL reset_done: got %b want 0", done); end
        nVec++; if (error !== 1'b0) begin nMis++; $display("FAIL reset_error: got %b want 0", error); end
        nVec++; if (rdata !== 32'h0) begin nMis++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        mr = 1'b0; ad = '0;
        @(negedge clk); rstN = 1'b1;
        @(negedge clk); #1;
        nVec++; if ({stall, done} !== 2'b00) begin nMis++; $display("FAIL idle_after_reset: got %b want 00", {stall, done}); end
    endtask

    task automatic test_word();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        sel = 2'd0;
        doReq(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok) begin nMis++; $display("FAIL sw_done: got none want pulse"); end
        nVec++; if (sc !== 2) begin nMis++; $display("FAIL sw_stall_cycles: got %0d want 2", sc); end
        nVec++; if (da !== 2) begin nMis++; $display("FAIL sw_done_cycle: got %0d want 2", da); end
        nVec++; if (e !== 1'b0) begin nMis++; $display("FAIL sw_error: got %b want 0", e); end
        doReq(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'hDEADBEEF) begin nMis++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        nVec++; if (e !== 1'b0) begin nMis++; $display("FAIL lw_error: got %b want 0", e); end
        @(negedge clk); #1;
        nVec++; if (done !== 1'b0) begin nMis++; $display("FAIL done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_byte_lane();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        sel = 2'd0;
        doReq(1'b0, 1'b1, 1'b0, 32'h80, 32'h11223344, 1'b0, ok, sc, da, e, rd);
        doReq(1'b0, 1'b1, 1'b1, 32'h82, 32'hFFFFFFAA, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || e !== 1'b0) begin nMis++; $display("FAIL sb_error: got %b want 0", e); end
        doReq(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'h11AA3344) begin nMis++; $display("FAIL sb_merge: got %h want 11aa3344", rd); end
        doReq(1'b1, 1'b0, 1'b1, 32'h83, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'h00000011) begin nMis++; $display("FAIL lb_lane3: got %h want 00000011", rd); end
        doReq(1'b1, 1'b0, 1'b1, 32'h82, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'h000000AA) begin nMis++; $display("FAIL lb_lane2: got %h want 000000aa", rd); end
    endtask

    task automatic test_latency();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        sel = 2'd1;
        doReq(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (sc !== 5) begin nMis++; $display("FAIL lat5_stall: got %0d want 5", sc); end
        nVec++; if (!ok || da !== 5) begin nMis++; $display("FAIL lat5_done_cycle: got %0d want 5", da); end
        nVec++; if (e !== 1'b0) begin nMis++; $display("FAIL lat5_error: got %b want 0", e); end
        sel = 2'd2;
        doReq(1'b0, 1'b1, 1'b0, 32'h4, 32'h55AA00FF, 1'b0, ok, sc, da, e, rd);
        nVec++; if (sc !== 1) begin nMis++; $display("FAIL lat1_stall: got %0d want 1", sc); end
        nVec++; if (!ok || da !== 1) begin nMis++; $display("FAIL lat1_done_cycle: got %0d want 1", da); end
        doReq(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'h55AA00FF) begin nMis++; $display("FAIL lat1_lw_data: got %h want 55aa00ff", rd); end
        sel = 2'd0;
    endtask

    task automatic test_illegal();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        sel = 2'd0;
        doReq(1'b1, 1'b0, 1'b0, 32'h42, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || e !== 1'b1) begin nMis++; $display("FAIL misaligned_lw_error: got %b want 1", e); end
        nVec++; if (rd !== 32'h0) begin nMis++; $display("FAIL misaligned_lw_rdata: got %h want 0", rd); end
        nVec++; if (sc !== 2) begin nMis++; $display("FAIL illegal_stall: got %0d want 2", sc); end
        doReq(1'b0, 1'b1, 1'b0, 32'h42, 32'h01020304, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || e !== 1'b1) begin nMis++; $display("FAIL misaligned_sw_error: got %b want 1", e); end
        doReq(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (rd !== 32'hDEADBEEF) begin nMis++; $display("FAIL misaligned_sw_nowrite: got %h want deadbeef", rd); end
        doReq(1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, ok, sc, da, e, rd);
        doReq(1'b0, 1'b1, 1'b0, 4 * Depth, 32'hFFFFFFFF, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || e !== 1'b1) begin nMis++; $display("FAIL range_sw_error: got %b want 1", e); end
        doReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (rd !== 32'hCAFEF00D) begin nMis++; $display("FAIL range_sw_nowrite: got %h want cafef00d", rd); end
        doReq(1'b1, 1'b1, 1'b0, 32'h0, 32'h0BADBAD0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || e !== 1'b1) begin nMis++; $display("FAIL rdwr_error: got %b want 1", e); end
        doReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (rd !== 32'hCAFEF00D) begin nMis++; $display("FAIL rdwr_nowrite: got %h want cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        sel = 2'd0;
        doReq(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, ok, sc, da, e, rd);
        doReq(1'b0, 1'b1, 1'b0, 32'h10, 32'h13579BDF, 1'b1, ok, sc, da, e, rd);
        // Next request presented during RESP, no gap.
        mr = 1'b1; mw = 1'b0; by = 1'b0; ad = 32'h10; wd = '0;
        doReq(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || da !== 2) begin nMis++; $display("FAIL b2b_done_cycle: got %0d want 2", da); end
        nVec++; if (sc !== 2) begin nMis++; $display("FAIL b2b_stall: got %0d want 2", sc); end
        nVec++; if (rd !== 32'h13579BDF) begin nMis++; $display("FAIL b2b_data: got %h want 13579bdf", rd); end
    endtask

    task automatic test_reset_mid();
        bit ok; int sc, da; logic e; logic [31:0] rd;
        int doneSeen;
        sel = 2'd0;
        doReq(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0, ok, sc, da, e, rd);
        @(negedge clk);
        mw = 1'b1; ad = 32'h20; wd = 32'h5;
        #1;
        nVec++; if (stall !== 1'b1) begin nMis++; $display("FAIL mid_req_stall: got %b want 1", stall); end
        @(negedge clk);
        rstN = 1'b0;
        #1;
        nVec++; if (stall !== 1'b0) begin nMis++; $display("FAIL mid_reset_stall: got %b want 0", stall); end
        @(negedge clk); #1;
        nVec++; if ({done, stall} !== 2'b00) begin nMis++; $display("FAIL mid_reset_done: got %b want 00", {done, stall}); end
        mw = 1'b0; ad = '0; wd = '0; rstN = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (done) doneSeen++;
        end
        nVec++; if (doneSeen !== 0) begin nMis++; $display("FAIL mid_reset_no_done: got %0d want 0", doneSeen); end
        doReq(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, ok, sc, da, e, rd);
        nVec++; if (!ok || rd !== 32'h12345678) begin nMis++; $display("FAIL mid_reset_old_data: got %h want 12345678", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lane();
        test_latency();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
